// File: rtl/pingpong_block_reader_if.sv
// Sample stream from the ping-pong block reader toward the processing chain.
// The master drives data/valid/last, the slave answers with ready.
interface pingpong_block_reader_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] data_s;
  logic             valid_s;
  logic             ready_s;
  logic             last_s;

  modport master (output data_s, output valid_s, output last_s, input ready_s);
  modport slave  (input data_s, input valid_s, input last_s, output ready_s);
endinterface

// File: rtl/pingpong_block_reader.sv
// Consumer side of the ping-pong sample buffer: drains each filled block over the read_enable/read_ack
// handshake, re-emits samples on a valid/ready stream, and reports per-block peak |sample| and overruns.
module pingpong_block_reader #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 256,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   buffer_ready_i,
  input  logic                   read_enable_i,
  input  logic [WIDTH-1:0]       read_data_i,
  output logic                   read_ack_o,
  pingpong_block_reader_if.master m,
  output logic                   block_done_o,
  output logic [WIDTH-1:0]       block_peak_o,
  output logic                   overrun_o,
  input  logic                   clear_i
);

  localparam int IDX_W = $clog2(DEPTH + 32'sd1);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 32'sd1);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_FULL - IDX_ONE;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    OUTPUT  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Magnitude of a two's-complement sample; the most negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
    if (x[WIDTH-1]) begin
      abs_mag = (~x) + W_ONE;
    end else begin
      abs_mag = x;
    end
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] acc_r;
  logic             restart_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             last_r;
  logic             ack_r;
  logic             done_r;
  logic [WIDTH-1:0] peak_r;
  logic             overrun_r;
  logic [WIDTH-1:0] sample_abs_s;
  logic             overrun_set_s;

  assign sample_abs_s  = abs_mag(read_data_i);
  assign overrun_set_s = buffer_ready_i && (state_r != IDLE) && (state_r != DONE);

  // Block sequencing: settle on the RAM, capture and ack one sample, present it, close the block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      idx_r     <= IDX_ZERO;
      acc_r     <= W_ZERO;
      restart_r <= 1'b0;
      data_r    <= W_ZERO;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      ack_r     <= 1'b0;
      done_r    <= 1'b0;
      peak_r    <= W_ZERO;
    end else begin
      ack_r  <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (read_enable_i) begin
            state_r <= SETTLE;
            cnt_r   <= CNT_LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        SETTLE: begin
          if (buffer_ready_i) begin
            cnt_r <= CNT_LOAD;
            idx_r <= IDX_ZERO;
            acc_r <= W_ZERO;
          end else if (cnt_r > CNT_ONE) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            // Counter parks at zero while the buffer has nothing to hand over.
            cnt_r <= CNT_ZERO;
            if (read_enable_i) begin
              state_r <= CAPTURE;
            end else begin
              state_r <= SETTLE;
            end
          end
        end
        CAPTURE: begin
          if (buffer_ready_i) begin
            state_r <= SETTLE;
            cnt_r   <= CNT_LOAD;
            idx_r   <= IDX_ZERO;
            acc_r   <= W_ZERO;
          end else if (read_enable_i) begin
            data_r  <= read_data_i;
            valid_r <= 1'b1;
            last_r  <= (idx_r == IDX_LAST);
            ack_r   <= 1'b1;
            idx_r   <= idx_r + IDX_ONE;
            if (sample_abs_s > acc_r) begin
              acc_r <= sample_abs_s;
            end else begin
              acc_r <= acc_r;
            end
            state_r <= OUTPUT;
          end else begin
            state_r <= SETTLE;
          end
        end
        OUTPUT: begin
          // A new block abandons the partial one, but the beat already offered is still delivered.
          if (buffer_ready_i) begin
            restart_r <= 1'b1;
            idx_r     <= IDX_ZERO;
            acc_r     <= W_ZERO;
          end else begin
            restart_r <= restart_r;
          end
          if (m.ready_s) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            cnt_r   <= CNT_LOAD;
            if (restart_r || buffer_ready_i) begin
              state_r   <= SETTLE;
              restart_r <= 1'b0;
              idx_r     <= IDX_ZERO;
            end else if (idx_r == IDX_FULL) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              peak_r  <= acc_r;
            end else begin
              state_r <= SETTLE;
            end
          end else begin
            state_r <= OUTPUT;
          end
        end
        DONE: begin
          acc_r   <= W_ZERO;
          idx_r   <= IDX_ZERO;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new overrun in the same cycle as clear_i keeps it set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_r <= 1'b0;
    end else if (overrun_set_s) begin
      overrun_r <= 1'b1;
    end else if (clear_i) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign read_ack_o   = ack_r;
  assign m.data_s     = data_r;
  assign m.valid_s    = valid_r;
  assign m.last_s     = last_r;
  assign block_done_o = done_r;
  assign block_peak_o = peak_r;
  assign overrun_o    = overrun_r;

endmodule

// File: tb/tb_pingpong_block_reader.sv
// Directed bench for pingpong_block_reader: a behavioural ping-pong buffer feeds blocks,
// a monitor records beats/acks/done pulses, and each scenario task checks its own results.
module tb_pingpong_block_reader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 256;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             buffer_ready_i;
  logic             read_enable_i;
  logic [WIDTH-1:0] read_data_i;
  logic             read_ack_o;
  logic             block_done_o;
  logic [WIDTH-1:0] block_peak_o;
  logic             overrun_o;
  logic             clear_i;

  pingpong_block_reader_if #(.WIDTH(WIDTH)) m_if ();

  pingpong_block_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .buffer_ready_i(buffer_ready_i), .read_enable_i(read_enable_i),
    .read_data_i(read_data_i), .read_ack_o(read_ack_o), .m(m_if), .block_done_o(block_done_o),
    .block_peak_o(block_peak_o), .overrun_o(overrun_o), .clear_i(clear_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Behavioural buffer: read pointer advances on ack, data appears one register stage after the address.
  logic [WIDTH-1:0] mem [DEPTH];
  int   addr = 0;
  logic loaded = 1'b0;
  logic gap = 1'b0;
  always @(posedge clk_i) begin
    if (buffer_ready_i) addr <= 0;
    else if (read_ack_o) addr <= addr + 1;
    read_data_i <= mem[addr[7:0]];
  end
  assign read_enable_i = loaded && (addr < DEPTH) && !gap;

  // Monitor: records accepted beats, acks and done pulses mid-cycle.
  int cyc = 0;
  logic [WIDTH-1:0] beat_q[$];
  bit   last_q[$];
  int   ack_q[$];
  int   done_q[$];
  int   last_acc_cyc = -1;
  int   ack_dis = 0;
  int   ack_consec = 0;
  logic prev_ack = 1'b0;
  always @(negedge clk_i) begin
    cyc = cyc + 1;
    if (m_if.valid_s && m_if.ready_s) begin
      beat_q.push_back(m_if.data_s);
      last_q.push_back(m_if.last_s);
      if (m_if.last_s) last_acc_cyc = cyc;
    end
    if (read_ack_o === 1'b1) begin
      ack_q.push_back(cyc);
      if (!read_enable_i) ack_dis = ack_dis + 1;
      if (prev_ack) ack_consec = ack_consec + 1;
    end
    if (block_done_o === 1'b1) done_q.push_back(cyc);
    prev_ack = read_ack_o;
  end

  task automatic clear_mon();
    beat_q.delete(); last_q.delete(); ack_q.delete(); done_q.delete();
    last_acc_cyc = -1;
  endtask

  task automatic start_block(input bit with_clear);
    @(posedge clk_i); #1;
    buffer_ready_i = 1'b1; clear_i = with_clear; loaded = 1'b1;
    @(posedge clk_i); #1;
    buffer_ready_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit to);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin @(negedge clk_i); #1; k++; end
    to = (beat_q.size() < n);
  endtask

  task automatic wait_done(input int n, input int budget, output bit to);
    int k = 0;
    while (done_q.size() < n && k < budget) begin @(negedge clk_i); #1; k++; end
    to = (done_q.size() < n);
    repeat (3) begin @(negedge clk_i); #1; end
  endtask

  task automatic test_reset();
    logic [2*WIDTH+4:0] obs;
    rst_i = 1'b1; buffer_ready_i = 1'b0; clear_i = 1'b0; m_if.ready_s = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    obs = {read_ack_o, m_if.valid_s, m_if.last_s, block_done_o, overrun_o, m_if.data_s, block_peak_o};
    checks++; if (obs !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    rst_i = 1'b0;
    repeat (5) begin @(negedge clk_i); #1; end
    obs = {read_ack_o, m_if.valid_s, m_if.last_s, block_done_o, overrun_o, m_if.data_s, block_peak_o};
    checks++; if (obs !== '0) begin failures++; $display("FAIL idle_outputs: got %h expected 0", obs); end
    checks++; if (ack_q.size() !== 0) begin failures++; $display("FAIL idle_no_ack: got %0d acks expected 0", ack_q.size()); end
  endtask

  task automatic test_ramp();
    bit to; int bad; int nlast;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i);
    start_block(1'b0);
    wait_done(1, 3000, to);
    checks++; if (to) begin failures++; $display("FAIL ramp_timeout: block_done not seen"); end
    checks++; if (beat_q.size() !== DEPTH) begin failures++; $display("FAIL ramp_beats: got %0d expected %0d", beat_q.size(), DEPTH); end
    for (int i = 0; i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== 16'(i)) begin failures++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, beat_q[i], i); end
    end
    nlast = 0;
    foreach (last_q[i]) if (last_q[i]) nlast++;
    checks++; if (nlast !== 1) begin failures++; $display("FAIL ramp_last_count: got %0d expected 1", nlast); end
    checks++; if (last_q.size() > 0 && last_q[last_q.size()-1] !== 1'b1) begin failures++; $display("FAIL ramp_last_pos: final beat lacks last"); end
    checks++; if (ack_q.size() !== DEPTH) begin failures++; $display("FAIL ramp_acks: got %0d expected %0d", ack_q.size(), DEPTH); end
    bad = 0;
    for (int i = 1; i < ack_q.size(); i++) if (ack_q[i] - ack_q[i-1] != 4) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL ramp_ack_spacing: got %0d gaps not 4 expected 0", bad); end
    checks++; if (done_q.size() > 0 && done_q[0] !== last_acc_cyc + 1) begin failures++; $display("FAIL ramp_done_timing: got cycle %0d expected %0d", done_q[0], last_acc_cyc + 1); end
    checks++; if (block_peak_o !== 16'd255) begin failures++; $display("FAIL ramp_peak: got %0d expected 255", block_peak_o); end
    checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL ramp_overrun: got %b expected 0", overrun_o); end
  endtask

  task automatic test_peak();
    bit to;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i % 64 - 32);
    mem[10] = 16'h8000; mem[20] = 16'd100;
    start_block(1'b0);
    wait_done(1, 3000, to);
    checks++; if (to || beat_q.size() !== DEPTH) begin failures++; $display("FAIL peak1_beats: got %0d expected %0d", beat_q.size(), DEPTH); end
    checks++; if (block_peak_o !== 16'h8000) begin failures++; $display("FAIL peak_most_negative: got %h expected 8000", block_peak_o); end
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'd7;
    start_block(1'b0);
    wait_done(1, 3000, to);
    checks++; if (to || beat_q.size() !== DEPTH) begin failures++; $display("FAIL peak2_beats: got %0d expected %0d", beat_q.size(), DEPTH); end
    checks++; if (block_peak_o !== 16'd7) begin failures++; $display("FAIL peak_all_seven: got %0d expected 7", block_peak_o); end
  endtask

  task automatic test_backpressure();
    bit to; int a0; int bad; int k;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(500 + i);
    start_block(1'b0);
    wait_beats(5, 200, to);
    @(posedge clk_i); #1; m_if.ready_s = 1'b0;
    k = 0;
    while (!m_if.valid_s && k < 20) begin @(negedge clk_i); #1; k++; end
    a0 = ack_q.size();
    for (int c = 0; c < 10; c++) begin
      checks++; if (m_if.valid_s !== 1'b1 || m_if.data_s !== 16'd505) begin failures++; $display("FAIL stall_hold[%0d]: got valid=%b data=%0d expected 1/505", c, m_if.valid_s, m_if.data_s); end
      @(negedge clk_i); #1;
    end
    checks++; if (ack_q.size() !== a0) begin failures++; $display("FAIL stall_no_ack: got %0d acks expected %0d", ack_q.size(), a0); end
    @(posedge clk_i); #1; m_if.ready_s = 1'b1;
    wait_done(1, 3000, to);
    bad = 0;
    for (int i = 0; i < beat_q.size(); i++) if (beat_q[i] !== 16'(500 + i)) bad++;
    checks++; if (to || beat_q.size() !== DEPTH || bad !== 0) begin failures++; $display("FAIL stall_sequence: got %0d beats %0d wrong expected %0d/0", beat_q.size(), bad, DEPTH); end
  endtask

  task automatic test_overrun();
    bit to; int bad; int nlast; int k;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i);
    start_block(1'b0);
    wait_beats(100, 1000, to);
    @(posedge clk_i); #1; m_if.ready_s = 1'b0;
    k = 0;
    while (!m_if.valid_s && k < 20) begin @(negedge clk_i); #1; k++; end
    checks++; if (m_if.data_s !== 16'd100) begin failures++; $display("FAIL ovr_held_beat: got %0d expected 100", m_if.data_s); end
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(1000 + i);
    start_block(1'b0);
    repeat (3) begin @(negedge clk_i); #1; end
    checks++; if (m_if.valid_s !== 1'b1 || m_if.data_s !== 16'd100) begin failures++; $display("FAIL ovr_not_retracted: got valid=%b data=%0d expected 1/100", m_if.valid_s, m_if.data_s); end
    checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", overrun_o); end
    checks++; if (block_peak_o !== 16'd755) begin failures++; $display("FAIL ovr_peak_kept: got %0d expected 755", block_peak_o); end
    @(posedge clk_i); #1; m_if.ready_s = 1'b1;
    wait_done(1, 3000, to);
    bad = 0;
    for (int i = 0; i < beat_q.size(); i++) if (beat_q[i] !== ((i <= 100) ? 16'(i) : 16'(1000 + i - 101))) bad++;
    checks++; if (to || beat_q.size() !== 101 + DEPTH || bad !== 0) begin failures++; $display("FAIL ovr_sequence: got %0d beats %0d wrong expected %0d/0", beat_q.size(), bad, 101 + DEPTH); end
    nlast = 0;
    foreach (last_q[i]) if (last_q[i]) nlast++;
    checks++; if (nlast !== 1 || done_q.size() !== 1) begin failures++; $display("FAIL ovr_partial_done: got last=%0d done=%0d expected 1/1", nlast, done_q.size()); end
    checks++; if (block_peak_o !== 16'd1255) begin failures++; $display("FAIL ovr_new_peak: got %0d expected 1255", block_peak_o); end
    @(posedge clk_i); #1; clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
    @(negedge clk_i); #1;
    checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end
  endtask

  task automatic test_overrun_clear_race();
    bit to; int bad;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(2000 + i);
    start_block(1'b0);
    wait_beats(3, 200, to);
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(6000 + i);
    start_block(1'b1);
    @(negedge clk_i); #1;
    checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL race_set_wins: got %b expected 1", overrun_o); end
    wait_done(1, 3000, to);
    bad = 0;
    for (int i = 0; i < beat_q.size(); i++) if (beat_q[i] !== ((i < 3) ? 16'(2000 + i) : 16'(6000 + i - 3))) bad++;
    checks++; if (to || beat_q.size() !== 3 + DEPTH || bad !== 0 || done_q.size() !== 1) begin failures++; $display("FAIL race_sequence: got %0d beats %0d wrong %0d done expected %0d/0/1", beat_q.size(), bad, done_q.size(), 3 + DEPTH); end
    checks++; if (block_peak_o !== 16'd6255) begin failures++; $display("FAIL race_peak: got %0d expected 6255", block_peak_o); end
    @(posedge clk_i); #1; clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
  endtask

  task automatic test_enable_gap();
    bit to; int a0; int bad;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(3000 + i);
    start_block(1'b0);
    wait_beats(10, 200, to);
    @(posedge clk_i); #1; gap = 1'b1;
    a0 = ack_q.size();
    repeat (3) begin @(negedge clk_i); #1; end
    checks++; if (ack_q.size() !== a0 || m_if.valid_s !== 1'b0) begin failures++; $display("FAIL gap_no_ack: got %0d acks valid=%b expected %0d/0", ack_q.size(), m_if.valid_s, a0); end
    @(posedge clk_i); #1; gap = 1'b0;
    wait_done(1, 3000, to);
    bad = 0;
    for (int i = 0; i < beat_q.size(); i++) if (beat_q[i] !== 16'(3000 + i)) bad++;
    checks++; if (to || beat_q.size() !== DEPTH || bad !== 0) begin failures++; $display("FAIL gap_sequence: got %0d beats %0d wrong expected %0d/0", beat_q.size(), bad, DEPTH); end
    checks++; if (ack_dis !== 0 || ack_consec !== 0) begin failures++; $display("FAIL ack_rules: got disabled=%0d consecutive=%0d expected 0/0", ack_dis, ack_consec); end
  endtask

  task automatic test_reset_mid();
    bit to; int a0; int bad;
    logic [2*WIDTH+4:0] obs;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(4000 + i);
    start_block(1'b0);
    wait_beats(50, 500, to);
    #2; rst_i = 1'b1; loaded = 1'b0;
    #1;
    obs = {read_ack_o, m_if.valid_s, m_if.last_s, block_done_o, overrun_o, m_if.data_s, block_peak_o};
    checks++; if (obs !== '0) begin failures++; $display("FAIL midreset_outputs: got %h expected 0", obs); end
    a0 = ack_q.size();
    repeat (3) begin @(negedge clk_i); #1; end
    checks++; if (ack_q.size() !== a0) begin failures++; $display("FAIL midreset_no_ack: got %0d expected %0d", ack_q.size(), a0); end
    @(posedge clk_i); #1; rst_i = 1'b0;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(7000 + i);
    start_block(1'b0);
    wait_done(1, 3000, to);
    bad = 0;
    for (int i = 0; i < beat_q.size(); i++) if (beat_q[i] !== 16'(7000 + i)) bad++;
    checks++; if (to || beat_q.size() !== DEPTH || bad !== 0) begin failures++; $display("FAIL post_reset_sequence: got %0d beats %0d wrong expected %0d/0", beat_q.size(), bad, DEPTH); end
    checks++; if (block_peak_o !== 16'd7255) begin failures++; $display("FAIL post_reset_peak: got %0d expected 7255", block_peak_o); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_peak();
    test_backpressure();
    test_overrun();
    test_overrun_clear_race();
    test_enable_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
